// File: rtl/ks_add_arbiter.sv
// Round-robin arbiter feeding one shared Kogge-Stone adder with a registered
// result slot; a requester can lock the adder across beats for multi-word adds.
module kogge_stone #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int LV = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] gn;
    logic [WIDTH-1:0] pn;
    logic [WIDTH-1:0] carries;

    always_comb begin
        p = a ^ b;
        g = a & b;
        // Fold the carry-in into bit 0 so the prefix tree needs no extra column.
        g[0] = g[0] | (p[0] & cin);
        gn = g;
        pn = p;
        for (int l = 0; l < LV; l++) begin
            gn = g;
            pn = p;
            for (int i = (1 << l); i < WIDTH; i++) begin
                gn[i] = g[i] | (p[i] & g[i - (1 << l)]);
                pn[i] = p[i] & p[i - (1 << l)];
            end
            g = gn;
            p = pn;
        end
        carries = {g[WIDTH-2:0], cin};
        sum     = (a ^ b) ^ carries;
        cout    = g[WIDTH-1];
    end
endmodule

module ks_add_arbiter #(
    parameter int WIDTH = 32,
    parameter int NREQ  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    input  logic [NREQ-1:0]       req_cin,
    input  logic [NREQ-1:0]       req_chain,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [1:0]            rsp_id,
    output logic [WIDTH-1:0]      rsp_sum,
    output logic                  rsp_cout,
    output logic                  dbg_lock
);
    // Handshake: a beat moves on a cycle where req_valid[i] and req_ready[i]
    // are both high; a result moves when rsp_valid and rsp_ready are both high.
    typedef enum logic {ARB = 1'b0, LOCK = 1'b1} state_t;

    state_t           state;
    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic [1:0]       gnt;
    logic [1:0]       ptr_next;
    logic             carry;
    logic             found;
    logic             slot_free;
    logic             accept;
    logic             add_cin;
    logic             add_cout;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] add_sum;

    always_comb begin
        found = 1'b0;
        gnt   = owner;
        if (state == LOCK) begin
            found = req_valid[owner];
        end else begin
            gnt = 2'd0;
            for (int k = 0; k < NREQ; k++) begin
                if (!found && req_valid[(int'(ptr) + k) % NREQ]) begin
                    found = 1'b1;
                    gnt   = 2'((int'(ptr) + k) % NREQ);
                end
            end
        end
    end

    assign slot_free = !rsp_valid || rsp_ready;
    assign accept    = found && slot_free && !rst;
    assign ptr_next  = (int'(gnt) == NREQ - 1) ? 2'd0 : gnt + 2'd1;
    assign dbg_lock  = (state == LOCK);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[gnt] = 1'b1;
        end
    end

    assign add_a   = req_a[int'(gnt)*WIDTH +: WIDTH];
    assign add_b   = req_b[int'(gnt)*WIDTH +: WIDTH];
    assign add_cin = (state == LOCK) ? carry : req_cin[gnt];

    kogge_stone #(.WIDTH(WIDTH)) u_adder (
        .a    (add_a),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= 2'd0;
            ptr       <= 2'd0;
            state     <= ARB;
            carry     <= 1'b0;
            owner     <= 2'd0;
        end else if (accept) begin
            rsp_valid <= 1'b1;
            rsp_sum   <= add_sum;
            rsp_cout  <= add_cout;
            rsp_id    <= gnt;
            if (req_chain[gnt]) begin
                state <= LOCK;
                owner <= gnt;
                carry <= add_cout;
            end else begin
                // Pointer only moves when the chain (if any) terminates.
                state <= ARB;
                ptr   <= ptr_next;
            end
        end else if (slot_free) begin
            rsp_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ks_add_arbiter.sv
// Bench for ks_add_arbiter: directed scenarios with literal expectations plus
// random traffic, all compared every cycle against an arithmetic reference.
module tb_ks_add_arbiter;
    localparam int W = 32;
    localparam int N = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a;
    logic [N*W-1:0] req_b;
    logic [N-1:0]   req_cin;
    logic [N-1:0]   req_chain;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [1:0]     rsp_id;
    logic [W-1:0]   rsp_sum;
    logic           rsp_cout;
    logic           dbg_lock;

    always #5 clk = ~clk;

    ks_add_arbiter #(.WIDTH(W), .NREQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .req_chain (req_chain),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .dbg_lock  (dbg_lock)
    );

    int total = 0;
    int bad   = 0;

    // Expected result slot contents: {id, cout, sum}; at most one entry.
    logic [W+2:0] exp_q[$];
    int m_ptr   = 0;
    int m_owner = 0;
    bit m_lock  = 1'b0;
    bit m_carry = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic cin, input logic chain);
        req_valid[i]      = v;
        req_a[i*W +: W]   = a;
        req_b[i*W +: W]   = b;
        req_cin[i]        = cin;
        req_chain[i]      = chain;
    endtask

    task automatic clr_inputs();
        rst       = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        req_chain = '0;
        rsp_ready = 1'b1;
    endtask

    task automatic model_grant(output bit found, output int g);
        int idx;
        found = 1'b0;
        g     = 0;
        if (m_lock) begin
            g     = m_owner;
            found = req_valid[m_owner];
        end else begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (!found && req_valid[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
        end
    endtask

    // One clock: compare DUT against the model, advance the model, cross the edge.
    task automatic step();
        bit           found;
        bit           free;
        int           g;
        logic [N-1:0] er;
        logic [W:0]   full;
        #1;
        model_grant(found, g);
        free = (exp_q.size() == 0) || rsp_ready;
        er   = '0;
        if (found && free && !rst) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("rsp_data", 64'({rsp_id, rsp_cout, rsp_sum}), 64'(exp_q[0]));
        chk("lock_state", 64'(dbg_lock), 64'(m_lock));
        if (rst) begin
            exp_q.delete();
            m_ptr   = 0;
            m_owner = 0;
            m_lock  = 1'b0;
            m_carry = 1'b0;
        end else begin
            if (free && exp_q.size() != 0) void'(exp_q.pop_front());
            if (found && free) begin
                full = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]}
                     + (W+1)'(m_lock ? m_carry : req_cin[g]);
                exp_q.push_back({2'(g), full[W], full[W-1:0]});
                if (req_chain[g]) begin
                    m_lock  = 1'b1;
                    m_owner = g;
                    m_carry = full[W];
                end else begin
                    m_lock = 1'b0;
                    m_ptr  = (g + 1) % N;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lit_rsp(input string name, input logic v, input logic [1:0] id,
                           input logic [W-1:0] sum, input logic cout);
        chk({name, ".valid"}, 64'(rsp_valid), 64'(v));
        if (v) begin
            chk({name, ".id"}, 64'(rsp_id), 64'(id));
            chk({name, ".sum"}, 64'(rsp_sum), 64'(sum));
            chk({name, ".cout"}, 64'(rsp_cout), 64'(cout));
        end
    endtask

    task automatic lit_ready(input string name, input logic [N-1:0] exp);
        #1;
        chk(name, 64'(req_ready), 64'(exp));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clr_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);

        // Reset values, with every requester asking during reset.
        req_valid = '1;
        lit_ready("reset_ready", 4'b0000);
        step();
        lit_rsp("reset_rsp", 1'b0, 2'd0, '0, 1'b0);
        chk("reset_sum", 64'(rsp_sum), 64'd0);
        chk("reset_id", 64'(rsp_id), 64'd0);
        chk("reset_cout", 64'(rsp_cout), 64'd0);
        clr_inputs();

        // Single add with overflow.
        set_req(0, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0);
        lit_ready("single_ready", 4'b0001);
        step();
        lit_rsp("single", 1'b1, 2'd0, 32'h0, 1'b1);
        clr_inputs();
        step();

        // Round-robin with all four requesters asking continuously.
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i * 100), 32'(i), 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            lit_ready("rr_ready", 4'(1 << (k % N)));
            step();
            lit_rsp("rr", 1'b1, 2'(k % N), 32'((k % N) * 101), 1'b0);
        end
        clr_inputs();
        step();

        // 64-bit chain from req2 while req1 keeps asking.
        do_reset();
        set_req(1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
        step();
        set_req(1, 1'b0, 32'd5, 32'd6, 1'b0, 1'b0);
        step();
        set_req(1, 1'b1, 32'd5, 32'd6, 1'b0, 1'b0);
        set_req(2, 1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1);
        lit_ready("chain1_ready", 4'b0100);
        step();
        lit_rsp("chain1", 1'b1, 2'd2, 32'h0, 1'b1);
        set_req(2, 1'b1, 32'd0, 32'd0, 1'b0, 1'b0);
        lit_ready("chain2_ready", 4'b0100);
        step();
        lit_rsp("chain2", 1'b1, 2'd2, 32'h1, 1'b0);
        set_req(2, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        lit_ready("chain_after", 4'b0010);
        step();
        lit_rsp("chain_after", 1'b1, 2'd1, 32'd11, 1'b0);
        clr_inputs();
        step();

        // Backpressure: result held three cycles, then drain and accept together.
        do_reset();
        set_req(0, 1'b1, 32'd10, 32'd20, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        step();
        set_req(0, 1'b0, 32'd10, 32'd20, 1'b0, 1'b0);
        set_req(1, 1'b1, 32'd3, 32'd4, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            lit_ready("bp_ready", 4'b0000);
            step();
            lit_rsp("bp_hold", 1'b1, 2'd0, 32'd30, 1'b0);
        end
        rsp_ready = 1'b1;
        lit_ready("bp_release", 4'b0010);
        step();
        lit_rsp("bp_next", 1'b1, 2'd1, 32'd7, 1'b0);
        clr_inputs();
        step();

        // Lock stall followed by reset abandoning the chain.
        do_reset();
        set_req(3, 1'b1, 32'd1, 32'd2, 1'b0, 1'b1);
        step();
        lit_rsp("lock_beat", 1'b1, 2'd3, 32'd3, 1'b0);
        set_req(3, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        set_req(0, 1'b1, 32'd0, 32'd0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            lit_ready("stall_ready", 4'b0000);
            step();
        end
        chk("stall_lock", 64'(dbg_lock), 64'd1);
        lit_rsp("stall_rsp", 1'b0, 2'd0, '0, 1'b0);
        do_reset();
        chk("abandon_lock", 64'(dbg_lock), 64'd0);
        lit_rsp("abandon_rsp", 1'b0, 2'd0, '0, 1'b0);
        lit_ready("abandon_ready", 4'b0001);
        step();
        lit_rsp("abandon_next", 1'b1, 2'd0, 32'h1, 1'b0);
        clr_inputs();
        step();

        // Random traffic checked against the reference every cycle.
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                set_req(i, $urandom_range(0, 3) != 0,
                        ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom),
                        32'($urandom), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3) == 0);
            end
            step();
        end
        clr_inputs();
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ks_add_arbiter.md
KS_ADD_ARBITER -- requirements
Module: ks_add_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand and sum width, equal to the width of the shared kogge_stone adder.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters; the grant ID is 2 bits wide.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 req_valid  in  NREQ  per-requester beat valid.
REQ-007 req_ready  out  NREQ  per-requester beat accepted; at most one bit high.
REQ-008 req_a  in  NREQ*WIDTH  operand A; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_b  in  NREQ*WIDTH  operand B, packed the same way.
REQ-010 req_cin  in  NREQ  carry-in, used only on the first beat of a chain.
REQ-011 req_chain  in  NREQ  when 1, the beat continues into a further beat (multi-word add).
REQ-012 rsp_valid  out  1  result register holds a result.
REQ-013 rsp_ready  in  1  consumer accepts the result.
REQ-014 rsp_id  out  2  index of the requester that owns the result.
REQ-015 rsp_sum  out  WIDTH  registered sum.
REQ-016 rsp_cout  out  1  registered carry-out of the MSB.

Function
REQ-017 SHALL instantiate exactly one combinational WIDTH-bit kogge_stone adder, shared by all requesters.
REQ-018 Result slot is free when rsp_valid==0 or rsp_ready==1; a beat SHALL be accepted only when the slot is free.
- Simultaneous drain and accept is allowed: one beat per cycle, full throughput.
REQ-019 In state ARB, the grant SHALL go to the first valid requester at or after pointer ptr, searching in round-robin order.
- req_ready[grant]=1 only when the slot is free; all other bits are 0.
REQ-020 On acceptance from requester g, ptr SHALL become (g+1) mod NREQ.
REQ-021 Adder inputs SHALL be the operands of the granted requester.
- Adder Cin = req_cin[g] in ARB.
- Adder Cin = carry register in LOCK.
REQ-022 On acceptance, the following SHALL be loaded one cycle later (latency 1):
- rsp_sum <= adder sum
- rsp_cout <= adder carry-out
- rsp_id <= g
- rsp_valid <= 1
REQ-023 Slot free with no accept SHALL clear rsp_valid. Slot not free SHALL hold rsp_sum, rsp_cout and rsp_id stable.
REQ-024 States SHALL be ARB and LOCK.
- ARB -> LOCK when an accepted beat has req_chain=1; owner <= g, carry <= adder carry-out.
- In LOCK, only the owner is eligible; other requesters see req_ready=0 even when valid.
- LOCK -> LOCK when an accepted beat has chain=1; carry updates.
- LOCK -> ARB when an accepted beat has chain=0.
REQ-025 In LOCK with req_valid[owner]==0, the block SHALL stall: no grant, state and carry held; the chain is never broken by other traffic.
REQ-026 In LOCK, ptr SHALL be held; it updates to owner+1 only on the terminating beat.
REQ-027 Arithmetic SHALL be modulo 2^WIDTH, with overflow reported only through rsp_cout; no sign handling.

Reset
REQ-028 While rst=1 at a clock edge, the following SHALL load:
- rsp_valid=0, rsp_sum=0, rsp_cout=0, rsp_id=0
- ptr=0, state=ARB, carry=0, owner=0
REQ-029 While rst=1, req_ready SHALL be all zeros.
REQ-030 Reset during LOCK SHALL abandon the chain; the next beat is treated as a first beat using req_cin.

Verification
REQ-031 Single add: req0 a=0xFFFF_FFFF, b=1, cin=0, chain=0, rsp_ready=1 -> next cycle rsp_valid=1, sum=0x0000_0000, cout=1, id=0.
REQ-032 Round-robin: all four valid continuously, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, one result per cycle with matching id.
REQ-033 64-bit chain: req2 beat1 a=0xFFFF_FFFF, b=1, cin=0, chain=1; beat2 a=0, b=0, chain=0; req1 valid throughout -> results (id2, 0x0, cout1) then (id2, 0x1, cout0); req1 is granted only after beat2.
REQ-034 Backpressure: rsp_ready=0 for 3 cycles with a result held -> req_ready all 0 and rsp_* stable; the first cycle rsp_ready=1 drains the result and accepts a new beat in the same cycle.
REQ-035 Lock stall plus reset: after a chain=1 beat from req3, req3 drops valid for 2 cycles -> no grants; then rst=1 for one cycle -> rsp_valid=0, state ARB, and req0 with cin=1, a=b=0 yields sum=0x1.
